// File: rtl/xor_parity_pkg.sv
// Shared types and helpers for the pipelined XOR parity block.
// Slots carry the unreduced data at the maximum supported width so one struct fits every instance.
package xor_parity_pkg;

  localparam int MAX_W     = 64;
  localparam int MAX_CNT_W = 32;

  // Bits reduced per stage; the last slice is implicitly zero-padded.
  function automatic int slice_w(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  function automatic logic [MAX_W-1:0] slice_mask(input int sw);
    if (sw >= MAX_W) return '1;
    return (64'd1 << sw) - 64'd1;
  endfunction

  typedef struct packed {
    logic             valid;
    logic             part;
    logic [MAX_W-1:0] data;
    logic             par;
    logic             odd;
    logic             check;
  } slot_t;

  // Increment that sticks at the all-ones value of a w-bit counter.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] v, input int w);
    logic [MAX_CNT_W-1:0] top;
    top = (w >= MAX_CNT_W) ? '1 : ((32'd1 << w) - 32'd1);
    if (v >= top) return top;
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/xor_parity_stage.sv
// One pipeline slot: folds the low slice of the carried data into the partial parity
// and shifts the remainder down for the next slot.
module xor_parity_stage
  import xor_parity_pkg::*;
#(
  parameter int SLICE_W = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  slot_t d,
  input  logic  next_ready,
  output slot_t q,
  output logic  ready
);

  localparam logic [MAX_W-1:0] MASK = slice_mask(SLICE_W);

  logic             slice_par;
  logic [MAX_W-1:0] rest;

  // Handshake: d is taken on an edge where d.valid && ready; this slot empties
  // or refills whenever it is empty or the downstream slot takes its word.
  assign ready     = !q.valid || next_ready;
  assign slice_par = ^(d.data & MASK);
  assign rest      = (SLICE_W >= MAX_W) ? '0 : (d.data >> SLICE_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (ready) begin
      q.valid <= d.valid;
      if (d.valid) begin
        q.part  <= d.part ^ slice_par;
        q.data  <= rest;
        q.par   <= d.par;
        q.odd   <= d.odd;
        q.check <= d.check;
      end
    end
  end

endmodule

// File: rtl/xor_parity_pipe.sv
// Pipelined XOR reduction with per-word generate/check mode and a saturating
// error counter; latency is STAGES cycles with one word per cycle throughput.
module xor_parity_pipe
  import xor_parity_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_par,
  input  logic             in_odd,
  input  logic             in_check,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_par,
  output logic             out_err,
  input  logic             clr_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int SLICE_W = slice_w(WIDTH, STAGES);

  slot_t in_slot;
  slot_t slot_q      [STAGES];
  logic  stage_ready [STAGES];
  slot_t last;
  logic  unused_tail;

  always_comb begin
    in_slot                   = '0;
    in_slot.valid             = in_valid;
    in_slot.data[WIDTH-1:0]   = in_data;
    in_slot.par               = in_par;
    in_slot.odd               = in_odd;
    in_slot.check             = in_check;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    slot_t d;
    logic  nr;
    if (k == 0) begin : g_first
      assign d = in_slot;
    end else begin : g_mid
      assign d = slot_q[k-1];
    end
    if (k == STAGES - 1) begin : g_last
      assign nr = out_ready;
    end else begin : g_inner
      assign nr = stage_ready[k+1];
    end
    xor_parity_stage #(.SLICE_W(SLICE_W)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .d          (d),
      .next_ready (nr),
      .q          (slot_q[k]),
      .ready      (stage_ready[k])
    );
  end

  assign in_ready  = stage_ready[0];
  assign last      = slot_q[STAGES-1];
  assign out_valid = last.valid;
  assign out_par   = last.part ^ last.odd;
  assign out_err   = last.check & (last.part ^ last.par ^ last.odd);

  // Every slice has been consumed by the last slot; its remainder is always zero.
  assign unused_tail = ^last.data;

  // Clear takes priority; stalled results only count once they transfer.
  always_ff @(posedge clk) begin
    if (rst || clr_count) begin
      err_count <= '0;
    end else if (out_valid && out_ready && out_err) begin
      err_count <= CNT_W'(sat_inc(MAX_CNT_W'(err_count), CNT_W));
    end
  end

endmodule
